baud_ctrl: RTL and testbench

BAUD_CTRL -- requirements
Module: baud_ctrl

---
 rtl/baud_ctrl_pkg.sv | 23 ++
 rtl/baud_ctrl_if.sv | 11 +
 rtl/baud_ctrl_rise_detect.sv | 25 ++
 rtl/baud_ctrl.sv | 135 +++++++++++++
 tb/tb_baud_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/baud_ctrl_pkg.sv
// Shared types and constants for the baud-rate change controller.
package baud_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_APPLY,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_CODE    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [2:0] BAUD_CODE_MAX = 3'd4;

  // Bits needed to hold a down-counter loaded with max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/baud_ctrl_if.sv
// Request/completion handshake between a host and the baud controller.
interface baud_ctrl_if;
  logic       req_valid;
  logic [2:0] req_baud;
  logic       req_ready;
  logic       done;
  logic [1:0] err;

  modport master (output req_valid, req_baud, input req_ready, done, err);
  modport slave  (input req_valid, req_baud, output req_ready, done, err);
endinterface

// File: rtl/baud_ctrl_rise_detect.sv
// Registered 0->1 detector; clr drops any pending edge and re-arms on the current level.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else if (clr) begin
      prev <= d;
      rise <= 1'b0;
    end else begin
      prev <= d;
      rise <= d & ~prev;
    end
  end

endmodule

// File: rtl/baud_ctrl.sv
// Baud change sequencer: drain the link, switch the code, pulse the dividers,
// then hold the link off for a guard interval of clk_16bd edges.
//
// state  | meaning
// IDLE   | ready for a request
// DRAIN  | link held, waiting for TX and RX idle (bounded by DRAIN_TIMEOUT)
// APPLY  | one cycle: new code driven, divider restart pulse
// SETTLE | counting GUARD_TICKS clk_16bd rising edges
// DONE   | one-cycle completion pulse with status
module baud_ctrl
  import baud_ctrl_pkg::*;
#(
  parameter int         GUARD_TICKS   = 16,
  parameter int         DRAIN_TIMEOUT = 65535,
  parameter logic [2:0] RESET_BAUD    = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  baud_ctrl_if.slave req,
  input  logic       tx_busy,
  input  logic       rx_busy,
  input  logic       clk_16bd,
  output logic [2:0] baud,
  output logic       div_rst,
  output logic       link_hold
);

  localparam int DRAIN_W = cnt_width(DRAIN_TIMEOUT);
  localparam int GUARD_W = cnt_width(GUARD_TICKS);

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_TICKS);
  localparam logic [GUARD_W-1:0] GUARD_ONE  = GUARD_W'(1);

  state_t             state;
  logic [2:0]         pend_baud;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [GUARD_W-1:0] guard_cnt;
  logic               tick_rise;
  logic               link_idle;
  logic               edge_clr;

  assign link_idle = !tx_busy && !rx_busy;
  assign edge_clr  = (state == ST_APPLY);

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .clr  (edge_clr),
    .d    (clk_16bd),
    .rise (tick_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      baud          <= RESET_BAUD;
      pend_baud     <= RESET_BAUD;
      div_rst       <= 1'b0;
      link_hold     <= 1'b0;
      drain_cnt     <= '0;
      guard_cnt     <= '0;
      req.req_ready <= 1'b0;
      req.done      <= 1'b0;
      req.err       <= ERR_OK;
    end else begin
      div_rst  <= 1'b0;
      req.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          req.req_ready <= 1'b1;
          if (req.req_valid && req.req_ready) begin
            req.req_ready <= 1'b0;
            if (req.req_baud > BAUD_CODE_MAX) begin
              state    <= ST_DONE;
              req.done <= 1'b1;
              req.err  <= ERR_CODE;
            end else if (req.req_baud == baud) begin
              state    <= ST_DONE;
              req.done <= 1'b1;
              req.err  <= ERR_OK;
            end else begin
              state     <= ST_DRAIN;
              pend_baud <= req.req_baud;
              drain_cnt <= DRAIN_LOAD;
              link_hold <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (link_idle) begin
            state   <= ST_APPLY;
            baud    <= pend_baud;
            div_rst <= 1'b1;
          end else if (drain_cnt <= DRAIN_ONE) begin
            // Terminal count: give up with the old code still in force.
            state     <= ST_DONE;
            req.done  <= 1'b1;
            req.err   <= ERR_TIMEOUT;
            link_hold <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_ONE;
          end
        end
        ST_APPLY: begin
          guard_cnt <= GUARD_LOAD;
          state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tick_rise) begin
            if (guard_cnt <= GUARD_ONE) begin
              state     <= ST_DONE;
              req.done  <= 1'b1;
              req.err   <= ERR_OK;
              link_hold <= 1'b0;
            end else begin
              guard_cnt <= guard_cnt - GUARD_ONE;
            end
          end
        end
        ST_DONE: begin
          state         <= ST_IDLE;
          req.req_ready <= 1'b1;
        end
        default: begin
          state         <= ST_IDLE;
          req.req_ready <= 1'b0;
          link_hold     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: per-cycle trace of inputs and outputs,
// expectations derived from the trace of bench-driven inputs only.
module tb_baud_ctrl;

  localparam int         G    = 16;
  localparam int         DT   = 50;
  localparam logic [2:0] RB   = 3'd0;
  localparam int         MAXC = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_busy, rx_busy, clk_16bd;
  logic [2:0] baud;
  logic       div_rst, link_hold;

  baud_ctrl_if bif();

  baud_ctrl #(.GUARD_TICKS(G), .DRAIN_TIMEOUT(DT), .RESET_BAUD(RB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (bif),
    .tx_busy   (tx_busy),
    .rx_busy   (rx_busy),
    .clk_16bd  (clk_16bd),
    .baud      (baud),
    .div_rst   (div_rst),
    .link_hold (link_hold)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tx_until = 0;
  int rx_until = 0;
  int per = 4;
  bit rx_stuck = 0;
  bit noise = 0;
  logic [2:0] m_baud;

  logic       t_tx [MAXC];
  logic       t_rx [MAXC];
  logic       t_c16 [MAXC];
  logic       t_done [MAXC];
  logic       t_div [MAXC];
  logic       t_hold [MAXC];
  logic       t_ready [MAXC];
  logic [1:0] t_err [MAXC];
  logic [2:0] t_baud [MAXC];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive inputs for cycle cyc, sample everything mid-cycle, advance.
  task automatic tick();
    tx_busy  = (cyc < tx_until) || (noise && ($urandom_range(0, 3) == 0));
    rx_busy  = rx_stuck || (cyc < rx_until) || (noise && ($urandom_range(0, 3) == 0));
    clk_16bd = ((cyc % per) == 0);
    @(negedge clk);
    if (cyc >= MAXC) begin
      $display("FAIL trace_overflow: cycle=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "trace overflow");
    end
    t_tx[cyc]    = tx_busy;
    t_rx[cyc]    = rx_busy;
    t_c16[cyc]   = clk_16bd;
    t_done[cyc]  = bif.done;
    t_div[cyc]   = div_rst;
    t_hold[cyc]  = link_hold;
    t_ready[cyc] = bif.req_ready;
    t_err[cyc]   = bif.err;
    t_baud[cyc]  = baud;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected done cycle for a request accepted in cycle a; -1 while the trace is too short.
  function automatic int model_done(input int a, input logic [2:0] code, input logic [2:0] old,
                                    output logic [1:0] e, output int p);
    int d;
    int cnt;
    e = 2'd0;
    p = -1;
    if (code > 3'd4) begin
      e = 2'd1;
      return a + 1;
    end
    if (code == old) return a + 1;
    d = -1;
    for (int t = a + 1; t <= a + DT; t++) begin
      if (t >= cyc) return -1;
      if (!t_tx[t] && !t_rx[t]) begin
        d = t;
        break;
      end
    end
    if (d < 0) begin
      e = 2'd2;
      return a + DT + 1;
    end
    p = d + 1;
    cnt = 0;
    for (int t = p + 1; t < cyc; t++) begin
      if (t_c16[t] && !t_c16[t-1]) begin
        cnt++;
        if (cnt == G) return t + 2;
      end
    end
    return -1;
  endfunction

  task automatic run_txn(input logic [2:0] code, input int busy_len, input bit use_rx,
                         input bit stuck, input bit noisy);
    int a, k, ed, p, n;
    int v_baud, v_div, v_hold, v_ready, v_done;
    logic [2:0] old, eb;
    logic [1:0] e;
    bit chg;
    a   = cyc;
    old = m_baud;
    chg = (code <= 3'd4) && (code != old);
    if (use_rx) rx_until = a + busy_len;
    else        tx_until = a + busy_len;
    rx_stuck = stuck;
    noise    = noisy;
    bif.req_valid = 1'b1;
    bif.req_baud  = code;
    tick();
    k = -1;
    n = 0;
    if (t_done[a] === 1'b1) k = a;
    ed = model_done(a, code, old, e, p);
    while (n < 600 && !(ed >= 0 && cyc > ed + 1)) begin
      bif.req_valid = noisy && !(ed >= 0 && cyc >= ed);
      bif.req_baud  = 3'($urandom_range(0, 7));
      tick();
      n++;
      if (k < 0 && t_done[cyc-1] === 1'b1) k = cyc - 1;
      ed = model_done(a, code, old, e, p);
    end
    bif.req_valid = 1'b0;
    noise    = 0;
    rx_stuck = 0;
    tx_until = 0;
    rx_until = 0;
    chk("ready_at_accept", t_ready[a], 1);
    chk("done_cycle", k, ed);
    if (ed >= 0 && cyc > ed + 1) begin
      chk("err_at_done", t_err[ed], e);
      v_baud = 0; v_div = 0; v_hold = 0; v_ready = 0; v_done = 0;
      for (int t = a; t <= ed + 1; t++) begin
        eb = (chg && e == 2'd0 && t >= p) ? code : old;
        if (t_baud[t] !== eb) v_baud++;
        if (t_div[t] !== (chg && e == 2'd0 && t == p)) v_div++;
        if (t_hold[t] !== (chg && t > a && t < ed)) v_hold++;
        if (t_ready[t] !== (t == a || t == ed + 1)) v_ready++;
        if (t_done[t] !== (t == ed)) v_done++;
      end
      chk("baud_trace", v_baud, 0);
      chk("div_rst_trace", v_div, 0);
      chk("link_hold_trace", v_hold, 0);
      chk("req_ready_trace", v_ready, 0);
      chk("done_trace", v_done, 0);
      m_baud = (chg && e == 2'd0) ? code : old;
    end
  endtask

  initial begin : stim
    int a, r, nd;
    logic [2:0] code;
    bif.req_valid = 1'b0;
    bif.req_baud  = 3'd0;
    tx_busy  = 1'b0;
    rx_busy  = 1'b0;
    clk_16bd = 1'b0;
    m_baud   = RB;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    tick(); tick(); tick();
    chk("rst_baud", t_baud[2], RB);
    chk("rst_div_rst", t_div[2], 0);
    chk("rst_link_hold", t_hold[2], 0);
    chk("rst_done", t_done[2], 0);
    chk("rst_err", t_err[2], 0);
    chk("rst_ready", t_ready[2], 0);
    rst = 1'b0;
    tick();
    tick();
    chk("ready_after_release", t_ready[cyc-1], 1);

    per = 4;
    run_txn(3'd3, 0, 0, 0, 0);
    run_txn(3'd1, 49, 0, 0, 0);
    run_txn(3'd2, 50, 1, 0, 0);
    run_txn(3'd0, 51, 0, 0, 0);
    run_txn(3'd6, 0, 0, 0, 0);
    run_txn(3'd7, 0, 0, 0, 1);
    run_txn(3'd4, 0, 1, 1, 0);
    run_txn(m_baud, 0, 0, 0, 1);
    per = 2;
    run_txn(3'd1, 5, 0, 0, 1);

    // Abort mid-guard interval with an asynchronous reset.
    per  = 3;
    a    = cyc;
    code = (m_baud == 3'd1) ? 3'd2 : 3'd1;
    bif.req_valid = 1'b1;
    bif.req_baud  = code;
    tick();
    bif.req_valid = 1'b0;
    repeat (6) tick();
    chk("pre_rst_div_rst", t_div[a+2], 1);
    chk("pre_rst_baud", t_baud[a+4], code);
    chk("pre_rst_link_hold", t_hold[a+6], 1);
    rst = 1'b1;
    tick();
    r = cyc - 1;
    chk("abort_baud", t_baud[r], RB);
    chk("abort_link_hold", t_hold[r], 0);
    chk("abort_done", t_done[r], 0);
    chk("abort_ready", t_ready[r], 0);
    chk("abort_err", t_err[r], 0);
    rst = 1'b0;
    tick();
    tick();
    chk("abort_ready_release", t_ready[r+2], 1);
    repeat (38) tick();
    nd = 0;
    for (int t = r; t < cyc; t++) if (t_done[t] !== 1'b0) nd++;
    chk("abort_no_done", nd, 0);
    m_baud = RB;
    run_txn(3'd4, 3, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      per  = $urandom_range(2, 5);
      code = ($urandom_range(0, 4) == 0) ? m_baud : 3'($urandom_range(0, 7));
      run_txn(code, $urandom_range(0, 60), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
